// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op/state encodings and op classification shared by muldiv_unit and its bench.
// Latency: none (types and pure functions only).
// Backpressure: none.
package muldiv_pkg;

    // RV32M funct3 encoding, used directly as the request opcode.
    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    // Ops whose rs1 operand is two's complement (MULHSU included: rs1 signed, rs2 not).
    function automatic logic is_signed_op(input muldiv_op_e op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    // Ops whose rs2 operand is two's complement.
    function automatic logic is_signed_b(input muldiv_op_e op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

    // Divide family shares bit 2 of funct3; bit 1 then selects remainder.
    function automatic logic is_div_op(input muldiv_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and muldiv_unit.
// Latency: none (wires only).
// Backpressure: valid/ready on both the request side and the result side.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    muldiv_op_e            op;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
    logic                  busy;

    // Requester side (execute stage / bench).
    modport master (
        output in_valid, op, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    // Unit side.
    modport slave (
        input  in_valid, op, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, busy
    );
endinterface

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one restoring-divide iteration (shift in a dividend bit, trial subtract).
// Latency: combinational.
// Backpressure: none.
module muldiv_div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_in,
    input  logic                  dividend_bit,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_out,
    output logic                  q_bit
);
    logic [DATA_WIDTH:0] shifted;

    // rem_in < divisor, so the shifted value is < 2*divisor and the restored
    // remainder always fits back into DATA_WIDTH bits.
    always_comb begin
        shifted = {rem_in, dividend_bit};
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? (shifted[DATA_WIDTH-1:0] - divisor) : shifted[DATA_WIDTH-1:0];
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide; MULDIV_FAST_MUL_EN selects a one-cycle multiplier.
// Latency: DATA_WIDTH+1 cycles accept-to-out_valid; 1 cycle for div-by-zero/overflow (and fast multiply).
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic   clk,
    input  logic   rst_n,
    muldiv_if.slave bus
);
    localparam int W2 = DATA_WIDTH + DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  CNT_LOAD = CNT_WIDTH'(DATA_WIDTH - 1);

    muldiv_state_e         state_q, state_d;
    muldiv_op_e            op_q, op_d;
    // Multiply: {product_hi, multiplier/product_lo}.  Divide: {remainder, dividend/quotient}.
    logic [W2-1:0]         acc_q, acc_d;
    // Multiplicand or divisor magnitude.
    logic [DATA_WIDTH-1:0] opnd_q, opnd_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;

    // Accept-side decode
    logic                  a_neg, b_neg;
    logic [DATA_WIDTH-1:0] a_mag, b_mag;
    logic                  div_zero, div_ovf, special;
    logic [DATA_WIDTH-1:0] special_res;

    // Iteration datapath
    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH-1:0] div_rem;
    logic                  div_q;
    logic [W2-1:0]         acc_step;
    logic [W2-1:0]         prod_signed;
    logic [DATA_WIDTH-1:0] div_pick;
    logic [DATA_WIDTH-1:0] final_res;

    // Operand signs/magnitudes and the cases that never need iterating.
    always_comb begin
        a_neg    = is_signed_op(bus.op) & bus.src_a[DATA_WIDTH-1];
        b_neg    = is_signed_b(bus.op) & bus.src_b[DATA_WIDTH-1];
        a_mag    = a_neg ? -bus.src_a : bus.src_a;
        b_mag    = b_neg ? -bus.src_b : bus.src_b;
        div_zero = (bus.src_b == '0);
        div_ovf  = ((bus.op == DIV) || (bus.op == REM)) &&
                   (bus.src_a == MOST_NEG) && (&bus.src_b);
        special  = is_div_op(bus.op) & (div_zero | div_ovf);
        if (div_zero) begin
            special_res = bus.op[1] ? bus.src_a : '1;
        end else begin
            special_res = bus.op[1] ? '0 : bus.src_a;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [W2-1:0]         fast_a, fast_b, fast_prod;
    logic [DATA_WIDTH-1:0] fast_res;

    // Sign-extend per op and take the low 2W bits of the full product.
    always_comb begin
        fast_a    = {{DATA_WIDTH{a_neg}}, bus.src_a};
        fast_b    = {{DATA_WIDTH{b_neg}}, bus.src_b};
        fast_prod = fast_a * fast_b;
        fast_res  = (bus.op == MUL) ? fast_prod[DATA_WIDTH-1:0] : fast_prod[W2-1:DATA_WIDTH];
    end
`endif

    muldiv_div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_div_step (
        .rem_in       (acc_q[W2-1:DATA_WIDTH]),
        .dividend_bit (acc_q[DATA_WIDTH-1]),
        .divisor      (opnd_q),
        .rem_out      (div_rem),
        .q_bit        (div_q)
    );

    // One radix-2 iteration: shift-add for multiply, restoring step for divide.
    always_comb begin
        mul_sum = {1'b0, acc_q[W2-1:DATA_WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        if (is_div_op(op_q)) begin
            acc_step = {div_rem, acc_q[DATA_WIDTH-2:0], div_q};
        end else begin
            acc_step = {mul_sum, acc_q[DATA_WIDTH-1:1]};
        end
    end

    // Sign fix-up and half selection applied to the last iteration's value.
    always_comb begin
        prod_signed = neg_q ? -acc_step : acc_step;
        div_pick    = op_q[1] ? acc_step[W2-1:DATA_WIDTH] : acc_step[DATA_WIDTH-1:0];
        if (is_div_op(op_q)) begin
            final_res = neg_q ? -div_pick : div_pick;
        end else if (op_q == MUL) begin
            final_res = prod_signed[DATA_WIDTH-1:0];
        end else begin
            final_res = prod_signed[W2-1:DATA_WIDTH];
        end
    end

    // Next-state and datapath-update logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d   = bus.op;
                    acc_d  = {{DATA_WIDTH{1'b0}}, a_mag};
                    opnd_d = b_mag;
                    neg_d  = (bus.op == REM) ? a_neg : (a_neg ^ b_neg);
                    if (special) begin
                        result_d = special_res;
                        zero_d   = (special_res == '0);
                        state_d  = DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!is_div_op(bus.op)) begin
                        result_d = fast_res;
                        zero_d   = (fast_res == '0);
                        state_d  = DONE;
                    end
`endif
                    else begin
                        cnt_d   = CNT_LOAD;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = acc_step;
                if (cnt_q == '0) begin
                    result_d = final_res;
                    zero_d   = (final_res == '0);
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= MUL;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed RV32M vectors against an arithmetic reference model and literals.
// Latency: measures accept-to-out_valid per op.
// Backpressure: stalls out_ready in DONE, holds a competing request, then releases.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;
    localparam int SPC_LAT = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if #(.DATA_WIDTH(W)) bus ();

    muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference: plain 64-bit arithmetic following the RV32M definitions.
    function automatic logic [31:0] model(input logic [2:0] opv, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ub_s;
        logic [63:0] ua, ub, p;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ua   = {32'b0, a};
        ub   = {32'b0, b};
        ub_s = longint'(ub);
        case (opv)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub_s); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = 64'(sa / sb);
                return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                p = 64'(sa % sb);
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Scoreboard compare: every cycle the result is presented it must match the oldest accepted op.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready_vs_busy", 32'(bus.in_ready), 32'(!bus.busy));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("out_valid_without_request", 32'(bus.out_valid), 32'd0);
                end else begin
                    check("sb_result", bus.result, exp_q[0]);
                    check("sb_zero", 32'(bus.zero), 32'(exp_q[0] == 32'd0));
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Waits (bounded) until in_ready is seen before an edge; caller then takes that edge.
    task automatic wait_ready(input string name);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
        end
        if (!ok) check({name, "_accept_timeout"}, 32'(bus.in_ready), 32'd1);
    endtask

    // Waits (bounded) for out_valid at negedges; returns cycles counted from the accept edge.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 200 && lat == 0; i++) begin
            @(negedge clk);
            if (bus.out_valid) lat = i;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] opv, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lit, input int exp_lat);
        int lat;
        check({name, "_model"}, model(opv, a, b), exp_lit);
        bus.op        = muldiv_op_e'(opv);
        bus.src_a     = a;
        bus.src_b     = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        wait_ready(name);
        @(posedge clk);
        #1;
        exp_q.push_back(model(opv, a, b));
        // Scramble inputs: the accepted operands must already be captured.
        bus.in_valid = 1'b0;
        bus.src_a    = ~a;
        bus.src_b    = b ^ 32'h5A5A_0F0F;
        bus.op       = muldiv_op_e'(~opv);
        wait_valid(lat);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_result"}, bus.result, exp_lit);
        check({name, "_zero"}, 32'(bus.zero), 32'(exp_lit == 32'd0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.op        = MUL;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_result",    bus.result,         32'd0);
        check("rst_zero",      32'(bus.zero),      32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul_7_m3",     3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulh_7_m3",    3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, MUL_LAT);
        run_op("mulhu_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulhsu_max",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run_op("mul_zero",     3'd0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, MUL_LAT);
        run_op("div_m20_6",    3'd4, 32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_m20_6",    3'd6, 32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFE, DIV_LAT);
        run_op("divu_20_6",    3'd5, 32'd20,        32'd6,         32'd3,         DIV_LAT);
        run_op("remu_20_6",    3'd7, 32'd20,        32'd6,         32'd2,         DIV_LAT);
        run_op("divu_max_1",   3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, DIV_LAT);
        run_op("div_5_0",      3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, SPC_LAT);
        run_op("rem_5_0",      3'd6, 32'd5,         32'd0,         32'd5,         SPC_LAT);
        run_op("divu_5_0",     3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, SPC_LAT);
        run_op("remu_5_0",     3'd7, 32'd5,         32'd0,         32'd5,         SPC_LAT);
        run_op("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
        run_op("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPC_LAT);

        // Backpressure: DIVU 20/6 finishes while out_ready is low; a competing request is held.
        bus.op        = DIVU;
        bus.src_a     = 32'd20;
        bus.src_b     = 32'd6;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        wait_ready("bp_first");
        @(posedge clk);
        #1;
        exp_q.push_back(model(3'd5, 32'd20, 32'd6));
        bus.op    = MULHU;
        bus.src_a = 32'hFFFF_FFFF;
        bus.src_b = 32'hFFFF_FFFF;
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'(DIV_LAT));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_result",   bus.result,          32'd3);
            check("bp_hold_valid",    32'(bus.out_valid),  32'd1);
            check("bp_hold_in_ready", 32'(bus.in_ready),   32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_valid",    32'(bus.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(bus.in_ready),  32'd1);
        check("bp_release_result",   bus.result,         32'd3);
        @(posedge clk);
        #1;
        exp_q.push_back(model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        check("bp_second_accepted", 32'(bus.busy), 32'd1);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("bp_second_latency", 32'(lat), 32'(MUL_LAT));
        check("bp_second_result", bus.result, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of an iterative divide.
        bus.op       = DIVU;
        bus.src_a    = 32'hFFFF_FFFF;
        bus.src_b    = 32'd3;
        bus.in_valid = 1'b1;
        wait_ready("rst_op");
        @(posedge clk);
        #1;
        exp_q.push_back(model(3'd5, 32'hFFFF_FFFF, 32'd3));
        bus.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_busy",      32'(bus.busy),      32'd0);
        check("mid_rst_zero",      32'(bus.zero),      32'd1);
        check("mid_rst_result",    bus.result,         32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, DIV_LAT);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
